// File: rtl/tri_thold_seq.sv
// tri_thold_seq: clock-control sequencer for the LCB control macros.
// Releases and re-asserts per-domain thold one domain at a time, spaced by
// STAGGER cycles, and walks the scan gate through a settle window on the
// way into and out of scan mode. Every output comes straight from a flop.
module tri_thold_seq #(
  parameter int NUM_DOM = 4,
  parameter int STAGGER = 2,
  parameter int SG_DLY  = 4
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               start_req,
  input  logic               stop_req,
  input  logic               scan_req,
  output logic [0:NUM_DOM-1] thold,
  output logic               sg,
  output logic               stopped,
  output logic               running,
  output logic               scan_active,
  output logic               busy,
  output logic               done,
  output logic               req_err
);

  localparam int MAX_DLY = (STAGGER > SG_DLY) ? STAGGER : SG_DLY;
  localparam int CW      = $clog2(MAX_DLY + 1);
  localparam int IW      = $clog2(NUM_DOM + 1);

  localparam logic [CW-1:0] STAGGER_C = CW'(STAGGER);
  localparam logic [CW-1:0] SG_DLY_C  = CW'(SG_DLY);
  localparam logic [IW-1:0] LAST_IDX  = IW'(NUM_DOM - 1);

  typedef enum logic [2:0] {
    ST_STOPPED,
    ST_STARTING,
    ST_RUNNING,
    ST_STOPPING,
    ST_SG_ON,
    ST_SCAN,
    ST_SG_OFF
  } state_t;

  state_t             state, state_nxt;
  logic [CW-1:0]      cnt, cnt_nxt;
  logic [IW-1:0]      idx, idx_nxt;
  logic [0:NUM_DOM-1] thold_nxt;
  logic               sg_nxt;
  logic               done_nxt;
  logic               err_nxt;

  // Next-state, counter, thold/sg and pulse decode; idx counts released domains.
  always_comb begin
    state_nxt = state;
    cnt_nxt   = cnt;
    idx_nxt   = idx;
    thold_nxt = thold;
    sg_nxt    = sg;
    done_nxt  = 1'b0;
    err_nxt   = 1'b0;
    case (state)
      ST_STOPPED: begin
        if (stop_req) begin
          state_nxt = ST_STOPPED;
        end else if (scan_req) begin
          state_nxt = ST_SG_ON;
          cnt_nxt   = SG_DLY_C;
        end else if (start_req) begin
          state_nxt = ST_STARTING;
          cnt_nxt   = STAGGER_C;
          idx_nxt   = '0;
        end
      end
      ST_STARTING: begin
        if (stop_req) begin
          state_nxt = ST_STOPPING;
          cnt_nxt   = STAGGER_C;
        end else begin
          err_nxt = scan_req | start_req;
          if (cnt <= 1) begin
            for (int k = 0; k < NUM_DOM; k++) begin
              if (k == int'(idx)) thold_nxt[k] = 1'b0;
            end
            idx_nxt = idx + 1'b1;
            cnt_nxt = STAGGER_C;
            if (idx == LAST_IDX) begin
              state_nxt = ST_RUNNING;
              done_nxt  = 1'b1;
            end
          end else begin
            cnt_nxt = cnt - 1'b1;
          end
        end
      end
      ST_RUNNING: begin
        if (stop_req) begin
          state_nxt = ST_STOPPING;
          cnt_nxt   = STAGGER_C;
        end else begin
          err_nxt = scan_req | start_req;
        end
      end
      ST_STOPPING: begin
        err_nxt = ~stop_req & (scan_req | start_req);
        if (idx == '0) begin
          state_nxt = ST_STOPPED;
          done_nxt  = 1'b1;
        end else if (cnt <= 1) begin
          for (int k = 0; k < NUM_DOM; k++) begin
            if (k == int'(idx) - 1) thold_nxt[k] = 1'b1;
          end
          idx_nxt = idx - 1'b1;
          cnt_nxt = STAGGER_C;
          if (idx == IW'(1)) begin
            state_nxt = ST_STOPPED;
            done_nxt  = 1'b1;
          end
        end else begin
          cnt_nxt = cnt - 1'b1;
        end
      end
      ST_SG_ON: begin
        if (!scan_req) begin
          state_nxt = ST_SG_OFF;
          cnt_nxt   = SG_DLY_C;
        end else if (cnt <= 1) begin
          state_nxt = ST_SCAN;
          sg_nxt    = 1'b1;
          done_nxt  = 1'b1;
          cnt_nxt   = '0;
        end else begin
          cnt_nxt = cnt - 1'b1;
        end
      end
      ST_SCAN: begin
        if (!scan_req) begin
          state_nxt = ST_SG_OFF;
          sg_nxt    = 1'b0;
          cnt_nxt   = SG_DLY_C;
        end else begin
          err_nxt = ~stop_req & start_req;
        end
      end
      ST_SG_OFF: begin
        sg_nxt = 1'b0;
        if (cnt <= 1) begin
          state_nxt = ST_STOPPED;
          done_nxt  = 1'b1;
          cnt_nxt   = '0;
        end else begin
          cnt_nxt = cnt - 1'b1;
        end
      end
      default: begin
        state_nxt = ST_STOPPED;
        thold_nxt = '1;
        sg_nxt    = 1'b0;
        cnt_nxt   = '0;
        idx_nxt   = '0;
      end
    endcase
  end

  // State, counters and all outputs registered; reset forces the safe idle values.
  always_ff @(posedge clk) begin
    if (rst) begin
      state       <= ST_STOPPED;
      cnt         <= '0;
      idx         <= '0;
      thold       <= '1;
      sg          <= 1'b0;
      stopped     <= 1'b1;
      running     <= 1'b0;
      scan_active <= 1'b0;
      busy        <= 1'b0;
      done        <= 1'b0;
      req_err     <= 1'b0;
    end else begin
      state       <= state_nxt;
      cnt         <= cnt_nxt;
      idx         <= idx_nxt;
      thold       <= thold_nxt;
      sg          <= sg_nxt;
      stopped     <= (state_nxt == ST_STOPPED);
      running     <= (state_nxt == ST_RUNNING);
      scan_active <= (state_nxt == ST_SCAN);
      busy        <= (state_nxt == ST_STARTING) || (state_nxt == ST_STOPPING) ||
                     (state_nxt == ST_SG_ON)    || (state_nxt == ST_SG_OFF);
      done        <= done_nxt;
      req_err     <= err_nxt;
    end
  end

endmodule

// File: tb/tb_tri_thold_seq.sv
// tb_tri_thold_seq: directed checks of the thold/sg sequencer with
// hand-computed expectations, plus invariant monitoring under random requests.
module tb_tri_thold_seq;

  localparam int ND = 4;

  logic          clk;
  logic          rst;
  logic          start_req;
  logic          stop_req;
  logic          scan_req;
  logic [0:ND-1] thold;
  logic          sg;
  logic          stopped;
  logic          running;
  logic          scan_active;
  logic          busy;
  logic          done;
  logic          req_err;

  int compared   = 0;
  int mismatched = 0;
  bit mon_en     = 1'b0;
  logic [0:ND-1] prev_thold;
  logic          prev_done;

  tri_thold_seq #(.NUM_DOM(ND), .STAGGER(2), .SG_DLY(4)) dut (
    .clk(clk), .rst(rst), .start_req(start_req), .stop_req(stop_req),
    .scan_req(scan_req), .thold(thold), .sg(sg), .stopped(stopped),
    .running(running), .scan_active(scan_active), .busy(busy),
    .done(done), .req_err(req_err)
  );

  // 10 ns clock
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // One active edge, returning at the following falling edge
  task automatic tick(input int n);
    for (int i = 0; i < n; i++) begin
      @(posedge clk);
      @(negedge clk);
    end
  endtask

  // Drive requests for one edge; start/stop are pulses, scan_req is a level
  task automatic applyStimulus(input logic st, input logic sp, input logic sc);
    start_req = st;
    stop_req  = sp;
    scan_req  = sc;
    tick(1);
    start_req = 1'b0;
    stop_req  = 1'b0;
  endtask

  // Compare every output against a hand-computed expectation
  task automatic checkOutput(input string tag, input logic [0:ND-1] e_th,
                             input logic e_sg, input logic e_st, input logic e_ru,
                             input logic e_sc, input logic e_bu, input logic e_dn,
                             input logic e_er);
    logic [10:0] got, exp;
    got = {thold, sg, stopped, running, scan_active, busy, done, req_err};
    exp = {e_th, e_sg, e_st, e_ru, e_sc, e_bu, e_dn, e_er};
    compared++;
    assert (got === exp) else begin
      mismatched++;
      $error("[TB] FAIL %s: got thold=%b sg/st/ru/sc/bu/dn/er=%b, expected thold=%b sg/st/ru/sc/bu/dn/er=%b",
             tag, got[10:7], got[6:0], exp[10:7], exp[6:0]);
    end
  endtask

  // Invariants sampled just after every active edge: sg implies all thold set,
  // one thold bit moves per cycle outside reset, done never on two cycles in a row
  always @(posedge clk) begin
    #1;
    if (mon_en) begin
      compared++;
      assert (!(sg === 1'b1) || (thold === {ND{1'b1}})) else begin
        mismatched++;
        $error("[TB] FAIL inv_sg_thold: got sg=%b thold=%b, expected thold=1111 while sg=1", sg, thold);
      end
      compared++;
      assert ((rst === 1'b1) || ($countones(thold ^ prev_thold) <= 1)) else begin
        mismatched++;
        $error("[TB] FAIL inv_one_bit: got thold %b -> %b, expected at most one bit change", prev_thold, thold);
      end
      compared++;
      assert (!(done === 1'b1 && prev_done === 1'b1)) else begin
        mismatched++;
        $error("[TB] FAIL inv_done_pulse: got done=1 on consecutive cycles, expected single-cycle pulse");
      end
    end
    prev_thold = thold;
    prev_done  = done;
  end

  initial begin
    rst = 1'b1; start_req = 1'b0; stop_req = 1'b0; scan_req = 1'b0;
    @(negedge clk);
    tick(2);
    rst = 1'b0;
    checkOutput("reset", 4'b1111, 0, 1, 0, 0, 0, 0, 0);
    mon_en = 1'b1;

    // Staggered release
    applyStimulus(1, 0, 0);
    checkOutput("t1_c0", 4'b1111, 0, 0, 0, 0, 1, 0, 0);
    tick(2); checkOutput("t1_c2", 4'b0111, 0, 0, 0, 0, 1, 0, 0);
    tick(2); checkOutput("t1_c4", 4'b0011, 0, 0, 0, 0, 1, 0, 0);
    tick(2); checkOutput("t1_c6", 4'b0001, 0, 0, 0, 0, 1, 0, 0);
    tick(1); checkOutput("t1_c7", 4'b0001, 0, 0, 0, 0, 1, 0, 0);
    tick(1); checkOutput("t1_c8", 4'b0000, 0, 0, 1, 0, 0, 1, 0);
    tick(1); checkOutput("t1_c9", 4'b0000, 0, 0, 1, 0, 0, 0, 0);

    // Staggered re-assert from RUNNING
    applyStimulus(0, 1, 0);
    checkOutput("t2_c0", 4'b0000, 0, 0, 0, 0, 1, 0, 0);
    tick(2); checkOutput("t2_c2", 4'b0001, 0, 0, 0, 0, 1, 0, 0);
    tick(2); checkOutput("t2_c4", 4'b0011, 0, 0, 0, 0, 1, 0, 0);
    tick(2); checkOutput("t2_c6", 4'b0111, 0, 0, 0, 0, 1, 0, 0);
    tick(2); checkOutput("t2_c8", 4'b1111, 0, 1, 0, 0, 0, 1, 0);
    tick(1); checkOutput("t2_c9", 4'b1111, 0, 1, 0, 0, 0, 0, 0);

    // Stop part-way through the release
    applyStimulus(1, 0, 0);
    tick(2); checkOutput("t3_c2", 4'b0111, 0, 0, 0, 0, 1, 0, 0);
    applyStimulus(0, 1, 0);
    checkOutput("t3_c3", 4'b0111, 0, 0, 0, 0, 1, 0, 0);
    tick(1); checkOutput("t3_c4", 4'b0111, 0, 0, 0, 0, 1, 0, 0);
    tick(1); checkOutput("t3_c5", 4'b1111, 0, 1, 0, 0, 0, 1, 0);

    // Scan entry, illegal start while scanning, scan exit
    applyStimulus(0, 0, 1);
    checkOutput("t4_sgon0", 4'b1111, 0, 0, 0, 0, 1, 0, 0);
    tick(3); checkOutput("t4_sgon3", 4'b1111, 0, 0, 0, 0, 1, 0, 0);
    tick(1); checkOutput("t4_scan4", 4'b1111, 1, 0, 0, 1, 0, 1, 0);
    tick(1); checkOutput("t4_scan5", 4'b1111, 1, 0, 0, 1, 0, 0, 0);
    applyStimulus(1, 0, 1);
    checkOutput("t4_scan_err", 4'b1111, 1, 0, 0, 1, 0, 0, 1);
    applyStimulus(0, 0, 0);
    checkOutput("t4_sgoff0", 4'b1111, 0, 0, 0, 0, 1, 0, 0);
    tick(3); checkOutput("t4_sgoff3", 4'b1111, 0, 0, 0, 0, 1, 0, 0);
    tick(1); checkOutput("t4_stop4", 4'b1111, 0, 1, 0, 0, 0, 1, 0);

    // Illegal requests in RUNNING and STARTING
    applyStimulus(1, 0, 0);
    tick(8); checkOutput("t5_run", 4'b0000, 0, 0, 1, 0, 0, 1, 0);
    applyStimulus(1, 0, 0);
    checkOutput("t5_err_start", 4'b0000, 0, 0, 1, 0, 0, 0, 1);
    tick(1); checkOutput("t5_err_clear", 4'b0000, 0, 0, 1, 0, 0, 0, 0);
    applyStimulus(0, 0, 1);
    scan_req = 1'b0;
    checkOutput("t5_err_scan_run", 4'b0000, 0, 0, 1, 0, 0, 0, 1);
    applyStimulus(0, 1, 0);
    tick(8); checkOutput("t5_stopped", 4'b1111, 0, 1, 0, 0, 0, 1, 0);
    applyStimulus(1, 0, 0);
    applyStimulus(0, 0, 1);
    scan_req = 1'b0;
    checkOutput("t5_err_scan_start", 4'b1111, 0, 0, 0, 0, 1, 0, 1);
    tick(1); checkOutput("t5_start_c2", 4'b0111, 0, 0, 0, 0, 1, 0, 0);
    applyStimulus(0, 1, 0);
    tick(2); checkOutput("t5_back_stop", 4'b1111, 0, 1, 0, 0, 0, 1, 0);
    applyStimulus(1, 1, 0);
    checkOutput("t5_stop_start_noop", 4'b1111, 0, 1, 0, 0, 0, 0, 0);

    // Abort before any domain released
    applyStimulus(1, 0, 0);
    applyStimulus(0, 1, 0);
    checkOutput("t5_abort_c1", 4'b1111, 0, 0, 0, 0, 1, 0, 0);
    tick(1); checkOutput("t5_abort_c2", 4'b1111, 0, 1, 0, 0, 0, 1, 0);

    // Reset mid-STARTING and mid-SCAN
    applyStimulus(1, 0, 0);
    tick(2);
    rst = 1'b1;
    tick(1); checkOutput("t6_rst_start", 4'b1111, 0, 1, 0, 0, 0, 0, 0);
    rst = 1'b0;
    tick(1); checkOutput("t6_after_rst", 4'b1111, 0, 1, 0, 0, 0, 0, 0);
    applyStimulus(0, 0, 1);
    tick(5); checkOutput("t6_in_scan", 4'b1111, 1, 0, 0, 1, 0, 0, 0);
    rst = 1'b1;
    tick(1); checkOutput("t6_rst_scan", 4'b1111, 0, 1, 0, 0, 0, 0, 0);
    rst = 1'b0; scan_req = 1'b0;
    tick(1); checkOutput("t6_after_rst2", 4'b1111, 0, 1, 0, 0, 0, 0, 0);

    // Random request stress; invariants watched by the monitor
    for (int i = 0; i < 400; i++) begin
      rst = ($urandom_range(0, 63) == 0);
      if ($urandom_range(0, 9) == 0) scan_req = ~scan_req;
      applyStimulus($urandom_range(0, 7) == 0, $urandom_range(0, 15) == 0, scan_req);
    end
    rst = 1'b1; scan_req = 1'b0;
    tick(1);
    rst = 1'b0;
    checkOutput("final_reset", 4'b1111, 0, 1, 0, 0, 0, 0, 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule
